// File: rtl/uop_sequencer.sv
// Control-unit front end: fetches 16-bit instructions and expands each opcode into a
// short sequence of 49-bit control words for ops_decoder, with memory-wait timeouts.
module uop_sequencer #(
    parameter int UOP_W    = 49,
    parameter int INS_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [INS_W-1:0] INS,
    input  logic             MEM_READY,
    input  logic             ZFLAG,
    output logic [UOP_W-1:0] uOPs,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam int B_DREAD   = 0;
    localparam int B_IREAD   = 1;
    localparam int B_DWRITE  = 2;
    localparam int B_BUSMEM  = 3;
    localparam int B_MEMBUSI = 4;
    localparam int B_PC_INC  = 29;
    localparam int B_PC_LOAD = 30;
    localparam int B_AC_CLR  = 31;
    localparam int B_HALT    = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MWAIT, S_DONE, S_ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [11:0]      pc;
    logic [INS_W-1:0] ir;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       opcode;
    logic             timeout, jump;
    logic [UOP_W-1:0] word;
    logic             busy_nxt, done_nxt, error_nxt;

    assign opcode  = ir[INS_W-1 -: 4];
    // The last permitted miss is the MAX_WAIT-th cycle; a READY on it still wins.
    assign timeout = (cnt == CNT_W'(MAX_WAIT - 1));
    assign jump    = (state == S_EXEC) && ((opcode == 4'h6) || ((opcode == 4'h7) && ZFLAG));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (START) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_FWAIT;
            S_FWAIT:  if (MEM_READY)    state_nxt = S_DECODE;
                      else if (timeout) state_nxt = S_ERROR;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    4'h1, 4'h2: state_nxt = S_MWAIT;
                    4'hF:       state_nxt = S_DONE;
                    default:    state_nxt = S_FETCH;
                endcase
            end
            S_MWAIT:  if (MEM_READY)    state_nxt = S_FETCH;
                      else if (timeout) state_nxt = S_ERROR;
            default:  state_nxt = state;
        endcase
    end

    always_comb begin
        word = '0;
        case (state)
            S_FETCH, S_FWAIT: begin
                word[B_IREAD]  = 1'b1;
                word[48:33]    = {4'h0, pc};
                word[B_PC_INC] = (state == S_FWAIT) && MEM_READY;
            end
            S_EXEC: begin
                case (opcode)
                    4'h1: begin
                        word[B_DREAD]   = 1'b1;
                        word[B_MEMBUSI] = 1'b1;
                        word[48:33]     = {4'h0, ir[11:0]};
                    end
                    4'h2: begin
                        word[B_DWRITE] = 1'b1;
                        word[B_BUSMEM] = 1'b1;
                        word[48:33]    = {4'h0, ir[11:0]};
                    end
                    4'h3, 4'h4: begin
                        word[8:5]   = ir[7:4];
                        word[24:9]  = 16'(1) << ir[3:0];
                        word[28:25] = (opcode == 4'h4) ? 4'd1 : 4'd0;
                    end
                    4'h5:    word[B_AC_CLR]  = 1'b1;
                    4'h6:    word[B_PC_LOAD] = 1'b1;
                    4'h7:    word[B_PC_LOAD] = ZFLAG;
                    4'hF:    word[B_HALT]    = 1'b1;
                    default: word = '0;
                endcase
            end
            S_MWAIT: word = uOPs;
            default: word = '0;
        endcase
        busy_nxt  = !(state_nxt inside {S_IDLE, S_DONE, S_ERROR});
        done_nxt  = (state_nxt == S_DONE);
        error_nxt = (state_nxt == S_ERROR);
    end

    // Control word lags the state by one register stage; flags track the state itself.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            uOPs  <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ERROR <= 1'b0;
        end else begin
            uOPs  <= word;
            BUSY  <= busy_nxt;
            DONE  <= done_nxt;
            ERROR <= error_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc  <= '0;
            ir  <= '0;
            cnt <= '0;
        end else begin
            if ((state == S_FWAIT) && MEM_READY) begin
                ir <= INS;
                pc <= pc + 12'd1;
            end
            if (jump) pc <= ir[11:0];
            // FETCH/EXEC always precede the wait states, so the count enters them at zero.
            if ((state == S_FWAIT) || (state == S_MWAIT)) cnt <= cnt + CNT_W'(1);
            else                                          cnt <= '0;
        end
    end
endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: table of single-instruction vectors, hand-built corner programs
// and random programs, all compared cycle by cycle against an instruction-level trace model.
module tb_uop_sequencer;
    localparam logic [48:0] DREAD   = 49'h1;
    localparam logic [48:0] IREAD   = 49'h2;
    localparam logic [48:0] DWRITE  = 49'h4;
    localparam logic [48:0] BUSMEM  = 49'h8;
    localparam logic [48:0] MEMBUSI = 49'h10;
    localparam logic [48:0] PC_INC  = 49'h1 << 29;
    localparam logic [48:0] PC_LOAD = 49'h1 << 30;
    localparam logic [48:0] AC_CLR  = 49'h1 << 31;
    localparam logic [48:0] HALT    = 49'h1 << 32;
    localparam int          MAXW    = 15;

    logic        CLK = 1'b0, RESET = 1'b0, START = 1'b0, MEM_READY = 1'b0, ZFLAG = 1'b0;
    logic [15:0] INS = '0;
    logic [48:0] uOPs;
    logic        BUSY, DONE, ERROR;

    int tests = 0, fails = 0;
    logic [15:0] iram [4096];

    typedef struct {
        bit          rdy;
        bit          st;
        logic [15:0] ins;
        bit          z;
        logic [48:0] w;
        bit          busy, done, err;
    } cyc_t;

    typedef struct {
        logic [15:0] ins;
        bit          z;
        logic [48:0] w;
        bit          chk;
        logic [11:0] nimm;
    } vec_t;

    cyc_t        tr[$];
    logic [48:0] cap[$];
    vec_t        v[12];

    always #5 CLK = ~CLK;

    uop_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .INS(INS), .MEM_READY(MEM_READY),
        .ZFLAG(ZFLAG), .uOPs(uOPs), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    task automatic check(input string nm, input int idx, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, got, exp);
        end
    endtask

    function automatic logic [48:0] imm(input logic [11:0] val);
        logic [48:0] r;
        r = '0;
        r[44:33] = val;
        return r;
    endfunction

    // One expected cycle: the word the current state produces plus its flags {busy,done,err}.
    function automatic void push(input logic [48:0] w, input bit rdy, input logic [15:0] ins,
                                 input bit z, input logic [2:0] fl);
        cyc_t c;
        c.w = w; c.rdy = rdy; c.ins = ins; c.z = z;
        c.busy = fl[2]; c.done = fl[1]; c.err = fl[0];
        c.st = fl[2] ? 1'($urandom % 2) : 1'b1;
        tr.push_back(c);
    endfunction

    function automatic int pick_lat(input int forced);
        int r;
        if (forced >= 0) return forced;
        r = $urandom_range(0, 19);
        return (r < 14) ? r % 4 : r - 3;
    endfunction

    function automatic void tail(input bit done);
        repeat (4) push(49'h0, 1'($urandom % 2), 16'($urandom), 1'($urandom % 2), done ? 3'b010 : 3'b001);
    endfunction

    function automatic void mem_wait(input logic [48:0] w, input logic [48:0] wdone,
                                     input logic [15:0] ins, input int lat, output bit err);
        err = 1'b0;
        for (int k = 0; ; k++) begin
            if (k == lat) begin
                push(wdone, 1'b1, ins, 1'($urandom % 2), 3'b100);
                return;
            end
            push(w, 1'b0, 16'($urandom), 1'($urandom % 2), 3'b100);
            if (k == MAXW - 1) begin
                err = 1'b1;
                return;
            end
        end
    endfunction

    // Instruction-level interpreter producing the expected per-cycle trace from PC=0.
    function automatic void build(input int max_ins, input int lat0, input int latn, input int zf);
        logic [11:0] pc;
        logic [15:0] ir;
        logic [48:0] w;
        logic [3:0]  op;
        bit          e, z;
        int          lat;
        pc = '0;
        lat = lat0;
        tr.delete();
        for (int n = 0; n < max_ins; n++) begin
            w = IREAD | imm(pc);
            push(w, 1'($urandom % 2), 16'($urandom), 1'($urandom % 2), 3'b100);
            mem_wait(w, w | PC_INC, iram[pc], pick_lat(lat), e);
            lat = latn;
            if (e) begin tail(1'b0); return; end
            ir = iram[pc];
            pc = pc + 12'd1;
            push(49'h0, 1'($urandom % 2), 16'($urandom), 1'($urandom % 2), 3'b100);
            z  = (zf < 0) ? 1'($urandom % 2) : zf[0];
            op = ir[15:12];
            w  = '0;
            case (op)
                4'h1: w = DREAD | MEMBUSI | imm(ir[11:0]);
                4'h2: w = DWRITE | BUSMEM | imm(ir[11:0]);
                4'h3, 4'h4: begin
                    w[8:5] = ir[7:4];
                    w[9 + ir[3:0]] = 1'b1;
                    if (op == 4'h4) w[28:25] = 4'd1;
                end
                4'h5: w = AC_CLR;
                4'h6: w = PC_LOAD;
                4'h7: w = z ? PC_LOAD : 49'h0;
                4'hF: w = HALT;
                default: w = '0;
            endcase
            push(w, 1'($urandom % 2), 16'($urandom), z, 3'b100);
            if (op == 4'h1 || op == 4'h2) begin
                mem_wait(w, w, 16'($urandom), pick_lat(latn), e);
                if (e) begin tail(1'b0); return; end
            end
            if (op == 4'hF) begin tail(1'b1); return; end
            if (op == 4'h6 || (op == 4'h7 && z)) pc = ir[11:0];
        end
    endfunction

    task automatic do_reset();
        RESET = 1'b0; START = 1'b0; MEM_READY = 1'b0; INS = '0; ZFLAG = 1'b0;
        @(negedge CLK);
        check("reset", 0, 64'({uOPs, BUSY, DONE, ERROR}), 64'h0);
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            MEM_READY = 1'b1;
            @(posedge CLK); #1;
            check("idle", i, 64'({uOPs, BUSY, DONE, ERROR}), 64'h0);
        end
        MEM_READY = 1'b0;
    endtask

    // Pulses START, then compares every cycle of tr; stop>=0 asserts reset in that cycle.
    task automatic run_trace(input int stop);
        logic [48:0] pw;
        cap.delete();
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int i = 0; i < tr.size(); i++) begin
            pw = (i == 0) ? 49'h0 : tr[i-1].w;
            cap.push_back(uOPs);
            check("trace", i, 64'({uOPs, BUSY, DONE, ERROR}),
                  64'({pw, tr[i].busy, tr[i].done, tr[i].err}));
            if (i == stop) begin
                RESET = 1'b0;
                #1;
                check("async_reset", i, 64'({uOPs, BUSY, DONE, ERROR}), 64'h0);
                return;
            end
            MEM_READY = tr[i].rdy; INS = tr[i].ins; ZFLAG = tr[i].z; START = tr[i].st;
            @(posedge CLK); #1;
        end
    endtask

    task automatic clear_iram();
        for (int j = 0; j < 4096; j++) iram[j] = '0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        v[0]  = '{16'h0000, 1'b0, 49'h0, 1'b1, 12'h001};
        v[1]  = '{16'h1034, 1'b0, DREAD | MEMBUSI | imm(12'h034), 1'b0, 12'h000};
        v[2]  = '{16'h2ABC, 1'b0, DWRITE | BUSMEM | imm(12'hABC), 1'b0, 12'h000};
        v[3]  = '{16'h3025, 1'b0, (49'h2 << 5) | (49'h1 << 14), 1'b1, 12'h001};
        v[4]  = '{16'h40F3, 1'b1, (49'h1 << 25) | (49'hF << 5) | (49'h1 << 12), 1'b1, 12'h001};
        v[5]  = '{16'h5000, 1'b0, AC_CLR, 1'b1, 12'h001};
        v[6]  = '{16'h6123, 1'b0, PC_LOAD, 1'b1, 12'h123};
        v[7]  = '{16'h7100, 1'b0, 49'h0, 1'b1, 12'h001};
        v[8]  = '{16'h7100, 1'b1, PC_LOAD, 1'b1, 12'h100};
        v[9]  = '{16'hF000, 1'b0, HALT, 1'b0, 12'h000};
        v[10] = '{16'h8FFF, 1'b1, 49'h0, 1'b1, 12'h001};
        v[11] = '{16'h6FFF, 1'b0, PC_LOAD, 1'b1, 12'hFFF};

        for (int i = 0; i < 12; i++) begin
            clear_iram();
            iram[0] = v[i].ins;
            do_reset();
            build(2, 0, 2, int'(v[i].z));
            run_trace(-1);
            check("vec_exec", i, 64'(cap[4]), 64'(v[i].w));
            if (v[i].chk) check("vec_next_fetch", i, 64'(cap[5][44:33]), 64'(v[i].nimm));
        end

        // Reset during EXEC of a LOAD, then a clean restart from PC=0.
        clear_iram();
        iram[0] = 16'h1034;
        iram[1] = 16'h5000;
        do_reset();
        build(3, 0, 2, -1);
        run_trace(3);
        do_reset();
        build(3, 2, 2, -1);
        run_trace(-1);

        // Fetch timeout, READY on the last allowed cycle, and data-access timeout.
        clear_iram();
        do_reset(); build(2, 15, 0, -1); run_trace(-1);
        check("fetch_timeout_error", 0, 64'(ERROR), 64'h1);
        do_reset(); build(2, 14, 0, -1); run_trace(-1);
        check("ready_on_last_cycle", 0, 64'(ERROR), 64'h0);
        iram[0] = 16'h2ABC;
        do_reset(); build(1, 0, 15, -1); run_trace(-1);
        check("mem_timeout_error", 0, 64'(ERROR), 64'h1);

        // NOP, CLR, HALT program.
        clear_iram();
        iram[0] = 16'h0000; iram[1] = 16'h5000; iram[2] = 16'hF000;
        do_reset(); build(10, -1, -1, -1); run_trace(-1);
        check("halt_done", 0, 64'({BUSY, DONE, ERROR}), 64'b010);

        // PC wrap from 0xFFF to 0.
        clear_iram();
        iram[0] = 16'h6FFF;
        iram[12'hFFF] = 16'h0000;
        do_reset(); build(5, 1, 1, -1); run_trace(-1);

        for (int p = 0; p < 25; p++) begin
            for (int j = 0; j < 4096; j++) iram[j] = 16'($urandom);
            do_reset();
            build(30, -1, -1, -1);
            run_trace(-1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
